// File: rtl/pc_irq_unit.sv
// pc_irq_unit: program counter with vectored, prioritised, nestable interrupts.
// The EPC stack holds {return pc, source id} per nesting level; index 0 is the
// outermost level and the entry at level-1 is the top.
// Ports:
//   clk, reset (async, active-low)
//   enable/button   input-wait hold and its release
//   halt            force pc to HALT_ADDR
//   jump/branch/out1ULA/addr   control-flow redirect
//   irq/irq_mask    level-sensitive requests, 1 = masked
//   reti            return from interrupt
//   loading/ctx_busy            pc stalls
//   ctx_restore_valid/ctx_restored_PC   install a restored pc as the top EPC
//   pc, JalAddress, EPC, irq_ack, in_isr, isr_level, active_irq (all registered)
module pc_irq_unit #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned NUM_IRQ    = 4,
   parameter int unsigned NEST_DEPTH = 2,
   parameter int unsigned RESET_ADDR = 0,
   parameter int unsigned ISR_BASE   = 83,
   parameter int unsigned ISR_STRIDE = 16,
   parameter int unsigned HALT_ADDR  = 157,
   parameter int unsigned USER_BASE  = 512
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        button,
   input  logic                        halt,
   input  logic                        jump,
   input  logic                        branch,
   input  logic                        out1ULA,
   input  logic [ADDR_W-1:0]           addr,
   input  logic [NUM_IRQ-1:0]          irq,
   input  logic [NUM_IRQ-1:0]          irq_mask,
   input  logic                        reti,
   input  logic                        loading,
   input  logic                        ctx_busy,
   input  logic                        ctx_restore_valid,
   input  logic [ADDR_W-1:0]           ctx_restored_PC,
   output logic [ADDR_W-1:0]           pc,
   output logic [ADDR_W-1:0]           JalAddress,
   output logic [ADDR_W-1:0]           EPC,
   output logic [NUM_IRQ-1:0]          irq_ack,
   output logic                        in_isr,
   output logic [$clog2(NEST_DEPTH+1)-1:0]                 isr_level,
   output logic [((NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1)-1:0] active_irq
);

   localparam int unsigned LVL_W = $clog2(NEST_DEPTH + 1);
   localparam int unsigned ID_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam int unsigned IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  jal_q, jal_d;
   logic [ADDR_W-1:0]  epc_q, epc_d;
   logic [NUM_IRQ-1:0] ack_q, ack_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [ID_W-1:0]    active_q, active_d;
   logic               in_isr_q, in_isr_d;
   logic [ADDR_W-1:0]  epc_stk_q [NEST_DEPTH];
   logic [ADDR_W-1:0]  epc_stk_d [NEST_DEPTH];
   logic [ID_W-1:0]    id_stk_q  [NEST_DEPTH];
   logic [ID_W-1:0]    id_stk_d  [NEST_DEPTH];

   logic [NUM_IRQ-1:0] eligible;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    top_id;
   logic [IDX_W-1:0]   top_idx;
   logic [IDX_W-1:0]   push_idx;
   logic [IDX_W-1:0]   next_top_idx;
   logic               has_lvl;
   logic               take;

   // Next-state: one fixed priority chain decides the whole cycle
   always_comb begin
      pc_d      = pc_q;
      jal_d     = jal_q;
      level_d   = level_q;
      ack_d     = '0;
      epc_stk_d = epc_stk_q;
      id_stk_d  = id_stk_q;

      eligible = irq & ~irq_mask;
      winner   = '0;
      // Scan downward so the lowest set index is the final winner
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) winner = ID_W'(i);
      end

      has_lvl  = (level_q != '0);
      top_idx  = IDX_W'(level_q - LVL_W'(1));
      push_idx = IDX_W'(level_q);
      top_id   = id_stk_q[top_idx];

      // ack_q guard stops a source whose clear is still in flight being re-taken
      take = (eligible != '0) && (ack_q == '0) && !halt && !enable && !ctx_busy &&
             (level_q < LVL_W'(NEST_DEPTH)) && (!has_lvl || (winner < top_id));

      if (take) begin
         epc_stk_d[push_idx] = pc_q + ADDR_W'(1);
         id_stk_d[push_idx]  = winner;
         pc_d    = ADDR_W'(ISR_BASE) + ADDR_W'(ADDR_W'(ISR_STRIDE) * ADDR_W'(winner));
         level_d = level_q + LVL_W'(1);
      end else if (ctx_restore_valid) begin
         if (has_lvl) begin
            epc_stk_d[top_idx] = ctx_restored_PC;
            ack_d[top_id]      = 1'b1;
         end else begin
            epc_stk_d[0] = ctx_restored_PC;
            id_stk_d[0]  = '0;
            level_d      = LVL_W'(1);
            ack_d[0]     = 1'b1;
         end
      end else if (reti && has_lvl) begin
         pc_d               = epc_stk_q[top_idx];
         epc_stk_d[top_idx] = '0;
         id_stk_d[top_idx]  = '0;
         level_d            = level_q - LVL_W'(1);
         ack_d[top_id]      = 1'b1;
      end else if (halt) begin
         pc_d = ADDR_W'(HALT_ADDR);
      end else if (enable && !button) begin
         pc_d = pc_q;
      end else if (jump) begin
         jal_d = pc_q + ADDR_W'(1);
         pc_d  = addr;
         // Jumping into user space abandons every open ISR level
         if (has_lvl && (32'(addr) >= 32'(USER_BASE))) begin
            level_d       = '0;
            ack_d[top_id] = 1'b1;
            for (int i = 0; i < NEST_DEPTH; i++) begin
               epc_stk_d[i] = '0;
               id_stk_d[i]  = '0;
            end
         end
      end else if (branch && out1ULA) begin
         pc_d = addr;
      end else if (ctx_busy || loading) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_q + ADDR_W'(1);
      end

      // Top-of-stack views are registered from the next stack state
      next_top_idx = IDX_W'(level_d - LVL_W'(1));
      in_isr_d     = (level_d != '0);
      epc_d        = in_isr_d ? epc_stk_d[next_top_idx] : '0;
      active_d     = in_isr_d ? id_stk_d[next_top_idx] : '0;
   end

   // State registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= ADDR_W'(RESET_ADDR);
         jal_q    <= '0;
         epc_q    <= '0;
         ack_q    <= '0;
         level_q  <= '0;
         active_q <= '0;
         in_isr_q <= 1'b0;
         for (int i = 0; i < NEST_DEPTH; i++) begin
            epc_stk_q[i] <= '0;
            id_stk_q[i]  <= '0;
         end
      end else begin
         pc_q      <= pc_d;
         jal_q     <= jal_d;
         epc_q     <= epc_d;
         ack_q     <= ack_d;
         level_q   <= level_d;
         active_q  <= active_d;
         in_isr_q  <= in_isr_d;
         epc_stk_q <= epc_stk_d;
         id_stk_q  <= id_stk_d;
      end
   end

   assign pc         = pc_q;
   assign JalAddress = jal_q;
   assign EPC        = epc_q;
   assign irq_ack    = ack_q;
   assign in_isr     = in_isr_q;
   assign isr_level  = level_q;
   assign active_irq = active_q;

endmodule

// File: doc/pc_irq_unit.md
Name: pc_irq_unit

Overview:
- Parametrised next-generation program counter for the processor core. Adds vectored multi-source interrupts, per-source masking and priority-based nesting backed by an EPC stack.
- Sits between the control unit / ALU branch output and instruction memory addressing.
- Also interfaces to the context-save engine: ctx_busy stalls the PC, and ctx_restore_valid installs a restored PC as an EPC.

Parameters:
- ADDR_W, 12: PC / address width.
- NUM_IRQ, 4: number of interrupt sources. Index 0 has the highest priority.
- NEST_DEPTH, 2: maximum interrupt nesting level and EPC stack depth (≥1).
- RESET_ADDR, 0: PC value after reset.
- ISR_BASE, 83: vector of source 0.
- ISR_STRIDE, 16: vector spacing. Vector i = ISR_BASE + i*ISR_STRIDE, taken mod 2^ADDR_W.
- HALT_ADDR, 157: PC forced while halt is asserted.
- USER_BASE, 512: jump target at or above this value unwinds all ISR levels.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  input-wait hold request.
- button  in  1  releases the enable hold.
- halt  in  1  halt request.
- jump  in  1  unconditional jump/jal.
- branch  in  1  conditional branch.
- out1ULA  in  1  ALU branch condition.
- addr  in  ADDR_W  jump/branch target.
- irq  in  NUM_IRQ  level-sensitive interrupt requests.
- irq_mask  in  NUM_IRQ  1 = source masked.
- reti  in  1  return from interrupt.
- loading  in  1  memory-load stall.
- ctx_busy  in  1  context engine busy stall.
- ctx_restore_valid  in  1  restored PC is valid (one-cycle pulse).
- ctx_restored_PC  in  ADDR_W  restored PC value.
- pc  out  ADDR_W  current PC.
- JalAddress  out  ADDR_W  link address (pc+1 captured on jump).
- EPC  out  ADDR_W  top-of-stack EPC; 0 when the stack is empty.
- irq_ack  out  NUM_IRQ  one-cycle clear pulse to the source being retired.
- in_isr  out  1  high when level > 0.
- isr_level  out  $clog2(NEST_DEPTH+1)  current nesting depth.
- active_irq  out  $clog2(NUM_IRQ) (min 1)  source ID at the top of stack; 0 when level 0.

Behaviour:
- Reset (reset low, asynchronous):
  - pc=RESET_ADDR.
  - JalAddress=0, irq_ack=0, level=0, active_irq=0.
  - All stack entries cleared, so EPC reads 0.
  - Reset may arrive mid-ISR or mid-stall; all nesting state is discarded.
- irq_ack defaults to 0 every cycle. It is high for exactly one cycle per retirement.
- Pending set: eligible = irq & ~irq_mask. Winner = lowest index set.
- Take condition (all must hold):
  - eligible ≠ 0;
  - irq_ack == 0 (one-cycle guard against re-taking a just-cleared level);
  - !halt, !enable, !ctx_busy;
  - level < NEST_DEPTH;
  - either level == 0 or winner index < active_irq (strictly higher priority).
- Per-cycle priority chain; the first match wins and all later items are ignored:
  1. Take: push {pc+1, winner}; pc <= vector(winner); level+1.
  2. ctx_restore_valid:
     - level > 0: top EPC <= ctx_restored_PC.
     - level == 0: push {ctx_restored_PC, id 0}, level=1.
     - In both cases: irq_ack[top id] pulse; pc unchanged.
  3. reti with level > 0: pc <= top EPC; pop; irq_ack[popped id] pulse. reti at level 0 falls through to item 4.
  4. halt: pc <= HALT_ADDR.
  5. enable && !button: pc holds.
  6. jump:
     - JalAddress <= pc+1; pc <= addr.
     - If level > 0 and addr ≥ USER_BASE: level <= 0, stack cleared, irq_ack[top id] pulse.
  7. branch && out1ULA: pc <= addr.
  8. ctx_busy or loading: pc holds.
  9. Otherwise: pc <= pc+1, wrapping mod 2^ADDR_W.
- Requests at level == NEST_DEPTH, or with equal/lower priority than active_irq, stay pending and are not lost; they are taken after reti.
- All additions are ADDR_W-bit, with the carry discarded.
- Outputs are registered, with zero combinational paths from inputs.

Test Plan:
- Reset low for 3 cycles mid-run, then release: pc=0, EPC=0, isr_level=0. pc increments 0,1,2… from the first rising edge after release.
- pc=10, irq=4'b0100 unmasked, no stalls → next pc=115 (83+2*16), EPC=11, active_irq=2. Then reti → pc=11, irq_ack=4'b0100 for one cycle, in_isr=0.
- Inside source-2 ISR, assert irq[0] → pc=83, isr_level=2, EPC=pc+1. With NEST_DEPTH=2 and level=2, a new irq[0] is not taken. After two reti, pc returns to the original 11.
- Inside an ISR, irq[3] (lower priority) asserted → no take until level 0. irq[1] with irq_mask[1]=1 → never taken.
- irq and halt asserted together → pc=157, no push. jump to addr=600 at level 2 → pc=600, level 0, one ack pulse. jump to addr=300 → level unchanged, JalAddress=pc+1.
- pc=4095, no events → pc=0. ctx_restore_valid with ctx_restored_PC=200 at level 0 → EPC=200, in_isr=1, irq_ack[0] pulse, pc unchanged.
